// File: rtl/potato_core.sv
// POTATO: multi-cycle, unpipelined RV32I core with one shared memory port.
// Define POTATO_ILLEGAL_HALT_EN to halt on unknown opcodes instead of NOP.
module potato_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write
);
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q, ir_q, a_q, b_q, imm_q, res_q, npc_q;
    logic [31:0] rf_q [32];
    logic        read_q, write_q;
    logic [31:0] addr_q, wdata_q;

    logic [31:0] imm_d, alu_d, npc_d, tgt, op_b;
    logic        take;

    logic [6:0] opc;
    logic [4:0] rd, rs1, rs2, sh;
    logic [2:0] f3;
    assign opc = ir_q[6:0];
    assign rd  = ir_q[11:7];
    assign f3  = ir_q[14:12];
    assign rs1 = ir_q[19:15];
    assign rs2 = ir_q[24:20];

    logic is_lui, is_auipc, is_jal, is_jalr, is_br;
    logic is_ld, is_st, is_opi, is_op, wr_en;
    assign is_lui   = (opc == 7'h37);
    assign is_auipc = (opc == 7'h17);
    assign is_jal   = (opc == 7'h6F);
    assign is_jalr  = (opc == 7'h67);
    assign is_br    = (opc == 7'h63);
    assign is_ld    = (opc == 7'h03);
    assign is_st    = (opc == 7'h23);
    assign is_opi   = (opc == 7'h13);
    assign is_op    = (opc == 7'h33);
    assign wr_en    = (rd != 5'd0) && (is_lui || is_auipc || is_jal
                    || is_jalr || is_ld || is_opi || is_op);
`ifdef POTATO_ILLEGAL_HALT_EN
    logic known;
    assign known = is_lui || is_auipc || is_jal || is_jalr || is_br
                 || is_ld || is_st || is_opi || is_op
                 || (opc == 7'h0F) || (opc == 7'h73);
`endif

    always_comb begin
        imm_d = '0;
        unique case (1'b1)
            is_lui, is_auipc: imm_d = {ir_q[31:12], 12'b0};
            is_jal:  imm_d = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20],
                              ir_q[30:21], 1'b0};
            is_br:   imm_d = {{20{ir_q[31]}}, ir_q[7], ir_q[30:25],
                              ir_q[11:8], 1'b0};
            is_st:   imm_d = {{21{ir_q[31]}}, ir_q[30:25], ir_q[11:7]};
            is_jalr, is_ld, is_opi:
                     imm_d = {{21{ir_q[31]}}, ir_q[30:20]};
            default: imm_d = '0;
        endcase
    end

    assign op_b = is_op ? b_q : imm_q;
    assign sh   = op_b[4:0];

    always_comb begin
        alu_d = '0;
        unique case (1'b1)
            is_lui:          alu_d = imm_q;
            is_auipc:        alu_d = pc_q + imm_q;
            is_jal, is_jalr: alu_d = pc_q + 32'd4;
            is_ld, is_st:    alu_d = a_q + imm_q;
            is_op, is_opi: begin
                case (f3)
                    3'd0: alu_d = (is_op && ir_q[30]) ? a_q - op_b
                                                      : a_q + op_b;
                    3'd1: alu_d = a_q << sh;
                    3'd2: alu_d = {31'b0, $signed(a_q) < $signed(op_b)};
                    3'd3: alu_d = {31'b0, a_q < op_b};
                    3'd4: alu_d = a_q ^ op_b;
                    3'd5: alu_d = ir_q[30] ? $unsigned($signed(a_q) >>> sh)
                                           : a_q >> sh;
                    3'd6: alu_d = a_q | op_b;
                    default: alu_d = a_q & op_b;
                endcase
            end
            default: alu_d = '0;
        endcase
    end

    always_comb begin
        take = 1'b0;
        case (f3)
            3'd0: take = (a_q == b_q);
            3'd1: take = (a_q != b_q);
            3'd4: take = ($signed(a_q) < $signed(b_q));
            3'd5: take = ($signed(a_q) >= $signed(b_q));
            3'd6: take = (a_q < b_q);
            3'd7: take = (a_q >= b_q);
            default: take = 1'b0;
        endcase
    end

    // Targets are word-aligned by force; JALR clears bit 0 first anyway.
    always_comb begin
        tgt = pc_q + 32'd4;
        unique case (1'b1)
            is_jal:         tgt = pc_q + imm_q;
            is_jalr:        tgt = (a_q + imm_q) & ~32'd1;
            (is_br && take): tgt = pc_q + imm_q;
            default:        tgt = pc_q + 32'd4;
        endcase
        npc_d = tgt & ~32'd3;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            res_q   <= '0;
            npc_q   <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (!read_q) begin
                        read_q <= 1'b1;
                        addr_q <= {pc_q[31:2], 2'b00};
                    end else if (mem_resp) begin
                        ir_q    <= mem_rdata;
                        read_q  <= 1'b0;
                        addr_q  <= '0;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    imm_q   <= imm_d;
                    a_q     <= rf_q[rs1];
                    b_q     <= rf_q[rs2];
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    res_q   <= alu_d;
                    npc_q   <= npc_d;
                    state_q <= (is_ld || is_st) ? S_MEM : S_WB;
`ifdef POTATO_ILLEGAL_HALT_EN
                    if (!known) state_q <= S_HALT;
`endif
                end
                S_MEM: begin
                    if (!read_q && !write_q) begin
                        read_q  <= is_ld;
                        write_q <= is_st;
                        addr_q  <= {res_q[31:2], 2'b00};
                        wdata_q <= is_st ? b_q : '0;
                    end else if (mem_resp) begin
                        if (is_ld) res_q <= mem_rdata;
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                        addr_q  <= '0;
                        wdata_q <= '0;
                        state_q <= S_WB;
                    end
                end
                S_WB: begin
                    if (wr_en) rf_q[rd] <= res_q;
                    pc_q    <= npc_q;
                    state_q <= S_FETCH;
                end
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign mem_read  = read_q;
    assign mem_write = write_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_potato_core.sv
// Directed bench for potato_core: program table plus reset/latency sequences.
// Expectations for the illegal-opcode vector follow POTATO_ILLEGAL_HALT_EN.
module tb_potato_core;
    localparam logic [31:0] LOOP = 32'h0000_006F;
    localparam logic [31:0] SPUR = 32'h1E00_2823;
    localparam int CYC = 600;
    localparam int NV = 16;

    typedef logic [7:0][31:0] prog_t;
    typedef struct {
        prog_t       p;
        int          lat;
        int          nwr;
        logic [31:0] wa;
        logic [31:0] wd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_resp = 1'b0;
    logic [31:0] mem_wdata, mem_addr;
    logic        mem_read, mem_write;

    always #5 clk = ~clk;

    potato_core #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .mem_wdata(mem_wdata), .mem_addr(mem_addr),
        .mem_read(mem_read), .mem_write(mem_write)
    );

    logic [31:0] mem [1024];
    int          lat = 0;
    int          cnt = 0;
    bit          spurious = 1'b0;
    int          wr_cnt = 0;
    logic [31:0] last_wa = '0, last_wd = '0;
    bit          bad = 1'b0;
    int          rst_req = 0;
    int          rises_n = 0;
    int          rise_t [16];
    int          cyc = 0;
    bit          prev_rd = 1'b0;
    logic        rst_pos = 1'b0;
    int          n_tests = 0, n_fail = 0;

    always @(posedge clk) rst_pos <= rst_n;

    // Memory model with lat wait cycles; logs stores and fetch timing.
    always @(negedge clk) begin
        cyc++;
        if (!rst_pos) begin
            wr_cnt = 0; last_wa = '0; last_wd = '0;
            bad = 1'b0; rises_n = 0; prev_rd = 1'b0;
            if (mem_read || mem_write) rst_req++;
        end else begin
            if (mem_read && mem_write) bad = 1'b1;
            if ((mem_read || mem_write) && mem_addr[1:0] != 2'b00) bad = 1'b1;
            if (mem_read && !prev_rd) begin
                if (rises_n < 16) rise_t[rises_n] = cyc;
                rises_n++;
            end
            prev_rd = mem_read;
        end
        if (!(mem_read || mem_write)) begin
            cnt = 0;
            mem_resp = spurious;
            mem_rdata = spurious ? SPUR : '0;
        end else if (cnt == lat) begin
            mem_resp = 1'b1;
            cnt++;
            if (mem_read) mem_rdata = mem[mem_addr[11:2]];
            else begin
                wr_cnt++;
                last_wa = mem_addr;
                last_wd = mem_wdata;
            end
        end else begin
            mem_resp = 1'b0;
            cnt++;
        end
    end

    function automatic logic [31:0] ei(int op, int f3, int rd, int rs1, int imm);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] er(int f7, int rs2, int rs1, int f3, int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] sw(int rs2, int imm);
        return {imm[11:5], rs2[4:0], 5'd0, 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] eb(int f3, int rs1, int rs2, int imm);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0],
                imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] ej(int rd, int imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
    endfunction
    function automatic logic [31:0] eu(int op, int rd, int imm);
        return {imm[19:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] addi(int rd, int rs1, int imm);
        return ei(7'h13, 0, rd, rs1, imm);
    endfunction

    function automatic prog_t pk(
        logic [31:0] i0 = LOOP, logic [31:0] i1 = LOOP,
        logic [31:0] i2 = LOOP, logic [31:0] i3 = LOOP,
        logic [31:0] i4 = LOOP, logic [31:0] i5 = LOOP,
        logic [31:0] i6 = LOOP, logic [31:0] i7 = LOOP);
        prog_t r;
        r[0] = i0; r[1] = i1; r[2] = i2; r[3] = i3;
        r[4] = i4; r[5] = i5; r[6] = i6; r[7] = i7;
        return r;
    endfunction

    function automatic vec_t mv(prog_t p, int l, int n,
                                logic [31:0] wa, logic [31:0] wd);
        vec_t v;
        v.p = p; v.lat = l; v.nwr = n; v.wa = wa; v.wd = wd;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_prog(prog_t p, int l);
        @(posedge clk); #1 rst_n = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[32'h200 >> 2] = 32'hFFFF_FFFE;
        for (int i = 0; i < 8; i++) mem[i] = p[i];
        lat = l;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (CYC) @(posedge clk);
        #1;
    endtask

    vec_t vecs [NV];

    initial begin
        vecs[0]  = mv(pk(addi(1, 0, 5), addi(2, 0, 3), er(32, 2, 1, 0, 3),
                         sw(3, 'h100)), 0, 1, 32'h100, 32'h2);
        vecs[1]  = mv(pk(addi(1, 0, 7), er(0, 1, 1, 0, 2), sw(2, 'h104)),
                      0, 1, 32'h104, 32'hE);
        vecs[2]  = mv(pk(addi(1, 0, 7), er(0, 1, 1, 0, 2), sw(2, 'h104)),
                      4, 1, 32'h104, 32'hE);
        vecs[3]  = mv(pk(ei(3, 2, 1, 0, 'h200), ei(7'h13, 5, 2, 1, 'h401),
                         sw(2, 'h10C)), 0, 1, 32'h10C, 32'hFFFF_FFFF);
        vecs[4]  = mv(pk(ei(3, 2, 1, 0, 'h200), ei(7'h13, 5, 2, 1, 1),
                         sw(2, 'h110)), 2, 1, 32'h110, 32'h7FFF_FFFF);
        vecs[5]  = mv(pk(eb(0, 0, 0, 8), sw(0, 'h150), addi(1, 0, 1),
                         sw(1, 'h114)), 0, 1, 32'h114, 32'h1);
        vecs[6]  = mv(pk(ej(1, 8), sw(0, 'h154), sw(1, 'h118)),
                      0, 1, 32'h118, 32'h4);
        vecs[7]  = mv(pk(addi(0, 0, 9), sw(0, 'h108)), 0, 1, 32'h108, 32'h0);
`ifdef POTATO_ILLEGAL_HALT_EN
        vecs[8]  = mv(pk(32'hFFFF_FFFF, addi(1, 0, 3), sw(1, 'h120)),
                      0, 0, 32'h0, 32'h0);
`else
        vecs[8]  = mv(pk(32'hFFFF_FFFF, addi(1, 0, 3), sw(1, 'h120)),
                      0, 1, 32'h120, 32'h3);
`endif
        vecs[9]  = mv(pk(eu(7'h37, 1, 'h12345), addi(1, 1, 'h678),
                         sw(1, 'h124)), 1, 1, 32'h124, 32'h1234_5678);
        vecs[10] = mv(pk(addi(1, 0, -1), er(0, 1, 0, 3, 2),
                         er(0, 0, 1, 2, 3), er(0, 3, 2, 0, 4),
                         sw(4, 'h12C)), 0, 1, 32'h12C, 32'h2);
        vecs[11] = mv(pk(addi(1, 0, 3), addi(2, 0, 0), addi(2, 2, 5),
                         addi(1, 1, -1), eb(1, 1, 0, -8), sw(2, 'h128)),
                      0, 1, 32'h128, 32'd15);
        vecs[12] = mv(pk(addi(1, 0, 'h10), ei(7'h67, 0, 2, 1, 3),
                         sw(0, 'h130), sw(0, 'h134), sw(2, 'h138)),
                      0, 1, 32'h138, 32'h8);
        vecs[13] = mv(pk(32'h0000_0073, eu(7'h17, 5, 1), sw(5, 'h13C)),
                      0, 1, 32'h13C, 32'h1004);
        vecs[14] = mv(pk(addi(1, 0, 'hF0), addi(2, 0, 'hFF),
                         er(0, 2, 1, 4, 3), ei(7'h13, 1, 3, 3, 4),
                         er(0, 2, 3, 7, 4), sw(4, 'h140)),
                      0, 1, 32'h140, 32'hF0);
        vecs[15] = mv(pk(addi(1, 0, -2), eb(4, 1, 0, 8), sw(0, 'h150),
                         eb(6, 1, 0, 8), addi(2, 0, 9), sw(2, 'h148)),
                      0, 1, 32'h148, 32'h9);

        for (int k = 0; k < NV; k++) begin
            run_prog(vecs[k].p, vecs[k].lat);
            check($sformatf("v%0d_nwr", k), wr_cnt, vecs[k].nwr);
            check($sformatf("v%0d_waddr", k), last_wa, vecs[k].wa);
            check($sformatf("v%0d_wdata", k), last_wd, vecs[k].wd);
            check($sformatf("v%0d_proto", k), {31'b0, bad}, 32'h0);
            if (k == 8) begin
`ifdef POTATO_ILLEGAL_HALT_EN
                check("halt_fetches", rises_n, 1);
                check("halt_idle", {30'b0, mem_read, mem_write}, 0);
`else
                check("nop_keeps_running", {31'b0, rises_n > 5}, 1);
`endif
            end
        end

        // Cycles between fetch requests: 5 per ALU op, 7 per store.
        run_prog(vecs[0].p, 0);
        check("lat0_alu", rise_t[1] - rise_t[0], 5);
        check("lat0_store", rise_t[4] - rise_t[3], 7);
        run_prog(vecs[0].p, 3);
        check("lat3_alu", rise_t[1] - rise_t[0], 8);
        check("lat3_store", rise_t[4] - rise_t[3], 13);

        // Reset while the core is spinning in its loop.
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_rw", {30'b0, mem_read, mem_write}, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4 && !mem_read; i++) @(negedge clk);
        check("first_fetch", {31'b0, mem_read}, 1);
        check("first_addr", mem_addr, 32'h0);

        // Reset during a slow fetch, with stray responses while idle.
        run_prog(pk(LOOP), 0);
        lat = 20;
        mem[0] = vecs[0].p[0]; mem[1] = vecs[0].p[1];
        mem[2] = vecs[0].p[2]; mem[3] = vecs[0].p[3];
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 4 && !mem_read; i++) @(negedge clk);
        check("mid_req_up", {31'b0, mem_read}, 1);
        @(posedge clk); #1 rst_n = 1'b0; spurious = 1'b1; lat = 0;
        @(posedge clk); #1;
        check("mid_req_drop", {31'b0, mem_read}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1 spurious = 1'b0;
        repeat (CYC) @(posedge clk);
        #1;
        check("mid_nwr", wr_cnt, 1);
        check("mid_waddr", last_wa, 32'h100);
        check("mid_wdata", last_wd, 32'h2);
        check("reset_no_requests", rst_req, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
